// File: rtl/zbt_av_arbiter_pkg.sv
// Shared types for the video/audio ZBT bank arbiter: FSM states, owner IDs and
// the read-return tag carried down the latency pipe.
package zbt_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_VIDEO = 2'd1,
    ARB_AUDIO = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_VIDEO = 1'b0,
    OWN_AUDIO = 1'b1
  } owner_t;

  localparam int AUDIO_PREEMPT_ACCEPTS = 4;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } read_tag_t;

endpackage

// File: rtl/zbt_av_arbiter_if.sv
// Bus bundle between the parser bitstream ports, the arbiter and the ZBT bank.
// The arbiter takes the slave view; the system/bench side takes the master view.
interface zbt_av_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
);
  logic              Video_Req_I;
  logic              Video_Write_En_I;
  logic [ADDR_W-1:0] Video_Address_I;
  logic [DATA_W-1:0] Video_Write_Data_I;
  logic              Video_Grant_O;
  logic              Video_Read_Valid_O;
  logic [DATA_W-1:0] Video_Read_Data_O;

  logic              Audio_Req_I;
  logic              Audio_Write_En_I;
  logic [ADDR_W-1:0] Audio_Address_I;
  logic [DATA_W-1:0] Audio_Write_Data_I;
  logic              Audio_Grant_O;
  logic              Audio_Read_Valid_O;
  logic [DATA_W-1:0] Audio_Read_Data_O;

  logic              ZBT_Busy_I;
  logic [ADDR_W-1:0] ZBT_Address_O;
  logic [DATA_W-1:0] ZBT_Write_Data_O;
  logic              ZBT_Write_En_O;
  logic [DATA_W-1:0] ZBT_Read_Data_I;

  modport slave (
    input  Video_Req_I, Video_Write_En_I, Video_Address_I, Video_Write_Data_I,
    output Video_Grant_O, Video_Read_Valid_O, Video_Read_Data_O,
    input  Audio_Req_I, Audio_Write_En_I, Audio_Address_I, Audio_Write_Data_I,
    output Audio_Grant_O, Audio_Read_Valid_O, Audio_Read_Data_O,
    input  ZBT_Busy_I, ZBT_Read_Data_I,
    output ZBT_Address_O, ZBT_Write_Data_O, ZBT_Write_En_O
  );

  modport master (
    output Video_Req_I, Video_Write_En_I, Video_Address_I, Video_Write_Data_I,
    input  Video_Grant_O, Video_Read_Valid_O, Video_Read_Data_O,
    output Audio_Req_I, Audio_Write_En_I, Audio_Address_I, Audio_Write_Data_I,
    input  Audio_Grant_O, Audio_Read_Valid_O, Audio_Read_Data_O,
    output ZBT_Busy_I, ZBT_Read_Data_I,
    input  ZBT_Address_O, ZBT_Write_Data_O, ZBT_Write_En_O
  );
endinterface

// File: rtl/zbt_read_tag_pipe.sv
// Fixed-depth shift register of {valid,owner} tags that tracks each accepted read
// until its data comes back from the bank.
module zbt_read_tag_pipe
  import zbt_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      resetn,
  input  read_tag_t push_tag,
  output read_tag_t pop_tag
);

  read_tag_t stage [DEPTH];

  // NOTE: the tag stages are plain flops, so they take the async reset; this is
  // what guarantees reads in flight at reset never produce a valid afterwards.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/zbt_av_arbiter.sv
// Video/audio arbiter for one pipelined ZBT bank: bounded-burst grants, same-cycle
// issue, tagged read return. Optional ZBT_ARB_AUDIO_PRIORITY_EN gives audio priority.
module zbt_av_arbiter
  import zbt_arb_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 4,
  parameter int MAX_BURST    = 16
) (
  input logic               clock,
  input logic               resetn,
  zbt_av_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  arb_state_t        state_q, state_d;
  cnt_t              burst_cnt_q, burst_cnt_d;
  owner_t            rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_wdata_q;

  logic              video_own, audio_own, own_req, other_req, accept;
  logic              own_we, burst_done, preempt_hit;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  arb_state_t        other_state, tie_state;
  read_tag_t         push_tag, pop_tag;
  logic              video_rvalid, audio_rvalid;

  assign video_own   = (state_q == ARB_VIDEO);
  assign audio_own   = (state_q == ARB_AUDIO);
  assign own_req     = (video_own & bus.Video_Req_I) | (audio_own & bus.Audio_Req_I);
  assign other_req   = (video_own & bus.Audio_Req_I) | (audio_own & bus.Video_Req_I);
  assign accept      = own_req & ~bus.ZBT_Busy_I;
  assign own_we      = audio_own ? bus.Audio_Write_En_I   : bus.Video_Write_En_I;
  assign own_addr    = audio_own ? bus.Audio_Address_I    : bus.Video_Address_I;
  assign own_wdata   = audio_own ? bus.Audio_Write_Data_I : bus.Video_Write_Data_I;
  assign other_state = audio_own ? ARB_VIDEO : ARB_AUDIO;

`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
  // A waiting audio request cuts a video burst short after a few accepts.
  assign tie_state   = ARB_AUDIO;
  assign preempt_hit = video_own & bus.Audio_Req_I &
                       (burst_cnt_q >= cnt_t'(AUDIO_PREEMPT_ACCEPTS - 1));
`else
  assign tie_state   = (rr_ptr_q == OWN_AUDIO) ? ARB_AUDIO : ARB_VIDEO;
  assign preempt_hit = 1'b0;
`endif

  assign burst_done = (burst_cnt_q == cnt_t'(MAX_BURST - 1)) | preempt_hit;

  // NOTE: every output of this block is given its hold value first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        burst_cnt_d = '0;
        if (bus.Video_Req_I && bus.Audio_Req_I) state_d = tie_state;
        else if (bus.Video_Req_I)               state_d = ARB_VIDEO;
        else if (bus.Audio_Req_I)               state_d = ARB_AUDIO;
      end
      default: begin
        if (!own_req) begin
          state_d     = other_req ? other_state : ARB_IDLE;
          burst_cnt_d = '0;
        end else if (accept) begin
          if (burst_done) begin
            burst_cnt_d = '0;
            if (other_req) state_d = other_state;
          end else begin
            burst_cnt_d = burst_cnt_q + cnt_t'(1);
          end
        end
      end
    endcase
    // The side just granted loses the next IDLE tie.
    rr_ptr_d = rr_ptr_q;
    if (state_d == ARB_VIDEO)      rr_ptr_d = OWN_AUDIO;
    else if (state_d == ARB_AUDIO) rr_ptr_d = OWN_VIDEO;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      burst_cnt_q  <= '0;
      rr_ptr_q     <= OWN_VIDEO;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      if (accept) begin
        last_addr_q  <= own_addr;
        last_wdata_q <= own_wdata;
      end
    end
  end

  // Bank side: live owner values on accept, otherwise hold the last issued ones.
  assign bus.ZBT_Write_En_O   = accept & own_we;
  assign bus.ZBT_Address_O    = accept ? own_addr  : last_addr_q;
  assign bus.ZBT_Write_Data_O = accept ? own_wdata : last_wdata_q;

  assign bus.Video_Grant_O = video_own;
  assign bus.Audio_Grant_O = audio_own;

  assign push_tag.valid = accept & ~own_we;
  assign push_tag.owner = audio_own ? OWN_AUDIO : OWN_VIDEO;

  zbt_read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clock    (clock),
    .resetn   (resetn),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  assign video_rvalid = pop_tag.valid & (pop_tag.owner == OWN_VIDEO);
  assign audio_rvalid = pop_tag.valid & (pop_tag.owner == OWN_AUDIO);

  assign bus.Video_Read_Valid_O = video_rvalid;
  assign bus.Audio_Read_Valid_O = audio_rvalid;
  assign bus.Video_Read_Data_O  = video_rvalid ? bus.ZBT_Read_Data_I : '0;
  assign bus.Audio_Read_Data_O  = audio_rvalid ? bus.ZBT_Read_Data_I : '0;

endmodule

// File: tb/tb_zbt_av_arbiter.sv
// Bench for zbt_av_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction-level arbitration model and a behavioural ZBT bank.
`timescale 1ns/1ps
module tb_zbt_av_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int RL     = 4;
  localparam int MB     = 16;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  zbt_av_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  zbt_av_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (RL),
    .MAX_BURST    (MB)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Requester queues and reference model state (owner: -1 none, 0 video, 1 audio)
  op_t               vq[$], aq[$];
  int                m_own = -1, m_cnt = 0, m_ptr = 0, cyc = 0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                exp_side [int];
  logic [DATA_W-1:0] rd_hist  [int];
  logic [DATA_W-1:0] mem      [int];
  logic [DATA_W-1:0] obs_v[$], obs_a[$];
  int                n_we = 0, n_idle = 0, n_sw = 0, prev_g = 0;
  int                n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] bank_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return DATA_W'(a);
  endfunction

  task automatic push_op(input int side, input int we, input int addr, input logic [DATA_W-1:0] wdata);
    op_t op;
    op.we    = (we != 0);
    op.addr  = ADDR_W'(addr);
    op.wdata = wdata;
    if (side == 0) vq.push_back(op);
    else           aq.push_back(op);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gv"},  64'(bus.Video_Grant_O), 64'd0);
    check({tag, "_ga"},  64'(bus.Audio_Grant_O), 64'd0);
    check({tag, "_we"},  64'(bus.ZBT_Write_En_O), 64'd0);
    check({tag, "_adr"}, 64'(bus.ZBT_Address_O), 64'd0);
    check({tag, "_wd"},  64'(bus.ZBT_Write_Data_O), 64'd0);
    check({tag, "_rvv"}, 64'(bus.Video_Read_Valid_O), 64'd0);
    check({tag, "_rva"}, 64'(bus.Audio_Read_Valid_O), 64'd0);
    check({tag, "_rdv"}, 64'(bus.Video_Read_Data_O), 64'd0);
    check({tag, "_rda"}, 64'(bus.Audio_Read_Data_O), 64'd0);
  endtask

  task automatic run_cycle(input logic busy);
    logic vr, ar, acc, ev, ea, oreq, xreq;
    op_t  op;
    int   lim, g;
    @(posedge clock);
    #1;
    cyc++;
    vr = (vq.size() > 0);
    ar = (aq.size() > 0);
    bus.Video_Req_I = vr;
    bus.Audio_Req_I = ar;
    if (vr) begin
      bus.Video_Write_En_I = vq[0].we; bus.Video_Address_I = vq[0].addr; bus.Video_Write_Data_I = vq[0].wdata;
    end else begin
      bus.Video_Write_En_I = 1'($urandom); bus.Video_Address_I = ADDR_W'($urandom); bus.Video_Write_Data_I = $urandom;
    end
    if (ar) begin
      bus.Audio_Write_En_I = aq[0].we; bus.Audio_Address_I = aq[0].addr; bus.Audio_Write_Data_I = aq[0].wdata;
    end else begin
      bus.Audio_Write_En_I = 1'($urandom); bus.Audio_Address_I = ADDR_W'($urandom); bus.Audio_Write_Data_I = $urandom;
    end
    bus.ZBT_Busy_I      = busy;
    bus.ZBT_Read_Data_I = rd_hist.exists(cyc - RL) ? rd_hist[cyc - RL] : DATA_W'($urandom);

    op  = '{we: 1'b0, addr: '0, wdata: '0};
    acc = 1'b0;
    if (m_own == 0 && vr) begin op = vq[0]; acc = !busy; end
    if (m_own == 1 && ar) begin op = aq[0]; acc = !busy; end
    ev = exp_side.exists(cyc) && exp_side[cyc] == 0;
    ea = exp_side.exists(cyc) && exp_side[cyc] == 1;

    @(negedge clock);
    check("grant_v",  64'(bus.Video_Grant_O), 64'(m_own == 0));
    check("grant_a",  64'(bus.Audio_Grant_O), 64'(m_own == 1));
    check("zbt_we",   64'(bus.ZBT_Write_En_O), 64'(acc && op.we));
    check("zbt_addr", 64'(bus.ZBT_Address_O), 64'(acc ? op.addr : m_addr));
    check("zbt_wd",   64'(bus.ZBT_Write_Data_O), 64'(acc ? op.wdata : m_wdata));
    check("rvalid_v", 64'(bus.Video_Read_Valid_O), 64'(ev));
    check("rvalid_a", 64'(bus.Audio_Read_Valid_O), 64'(ea));
    if (ev) check("rdata_v", 64'(bus.Video_Read_Data_O), 64'(rd_hist[cyc - RL]));
    if (ea) check("rdata_a", 64'(bus.Audio_Read_Data_O), 64'(rd_hist[cyc - RL]));

    if (bus.Video_Read_Valid_O) obs_v.push_back(bus.Video_Read_Data_O);
    if (bus.Audio_Read_Valid_O) obs_a.push_back(bus.Audio_Read_Data_O);
    if (bus.ZBT_Write_En_O) n_we++;
    g = bus.Video_Grant_O ? 1 : (bus.Audio_Grant_O ? 2 : 0);
    if ((vr || ar) && g == 0) n_idle++;
    if (prev_g != 0 && g != 0 && g != prev_g) n_sw++;
    prev_g = g;

    // Bank: the read value is the memory contents at issue time.
    rd_hist[cyc] = bank_rd(acc ? op.addr : m_addr);
    if (acc) begin
      if (op.we) mem[int'(op.addr)] = op.wdata;
      else       exp_side[cyc + RL] = m_own;
      m_addr  = op.addr;
      m_wdata = op.wdata;
      if (m_own == 0) void'(vq.pop_front());
      else            void'(aq.pop_front());
    end

    // Arbitration rules: IDLE grants next cycle, bursts bounded while the other waits.
    if (m_own < 0) begin
`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
      if (vr && ar) m_own = 1;
`else
      if (vr && ar) m_own = m_ptr;
`endif
      else if (vr) m_own = 0;
      else if (ar) m_own = 1;
      m_cnt = 0;
    end else begin
      oreq = (m_own == 0) ? vr : ar;
      xreq = (m_own == 0) ? ar : vr;
      if (!oreq) begin
        m_own = xreq ? 1 - m_own : -1;
        m_cnt = 0;
      end else if (acc) begin
        lim = MB;
`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
        if (m_own == 0 && ar) lim = 4;
`endif
        if (m_cnt + 1 >= lim) begin
          m_cnt = 0;
          if (xreq) m_own = 1 - m_own;
        end else begin
          m_cnt++;
        end
      end
    end
    if (m_own >= 0) m_ptr = 1 - m_own;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (vq.size() > 0 || aq.size() > 0); i++) run_cycle(1'b0);
    check("drained", 64'(vq.size() + aq.size()), 64'd0);
    repeat (RL + 2) run_cycle(1'b0);
  endtask

  initial begin
    int we_before;
    bus.Video_Req_I = 0; bus.Video_Write_En_I = 0; bus.Video_Address_I = '0; bus.Video_Write_Data_I = '0;
    bus.Audio_Req_I = 0; bus.Audio_Write_En_I = 0; bus.Audio_Address_I = '0; bus.Audio_Write_Data_I = '0;
    bus.ZBT_Busy_I = 0; bus.ZBT_Read_Data_I = 32'hA5A5_5A5A;
    #12;
    check_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Video-only reads, bank returns mem=addr
    for (int i = 0; i < 3; i++) push_op(0, 0, 'h10 + i, '0);
    drain(20);
    check("t1_count", 64'(obs_v.size()), 64'd3);
    for (int i = 0; i < 3 && i < obs_v.size(); i++) check("t1_data", 64'(obs_v[i]), 64'('h10 + i));
    check("t1_audio_none", 64'(obs_a.size()), 64'd0);

    // Both sides streaming: alternating bursts of MB accepts, no dead cycles
    for (int i = 0; i < 64; i++) begin
      push_op(0, 0, 'h100 + i, '0);
      push_op(1, 0, 'h200 + i, '0);
    end
    n_idle = 0; n_sw = 0; prev_g = 0;
    drain(400);
    check("t2_idle", 64'(n_idle), 64'd1);
    check("t2_switches", 64'(n_sw), 64'd7);

    // Audio write then readback
    obs_a.delete(); n_we = 0;
    push_op(1, 1, 'h40000, 32'hDEAD_BEEF);
    push_op(1, 0, 'h40000, '0);
    drain(20);
    check("t3_we_count", 64'(n_we), 64'd1);
    check("t3_rb_count", 64'(obs_a.size()), 64'd1);
    if (obs_a.size() > 0) check("t3_rb_data", 64'(obs_a[0]), 64'h0000_0000_DEAD_BEEF);

    // Busy stall in the middle of a video write burst
    n_we = 0;
    for (int i = 0; i < 8; i++) push_op(0, 1, 'h300 + i, 32'h1000 + i);
    repeat (3) run_cycle(1'b0);
    we_before = n_we;
    repeat (5) run_cycle(1'b1);
    check("t4_busy_we", 64'(n_we - we_before), 64'd0);
    drain(30);
    check("t4_we_total", 64'(n_we), 64'd8);

    // Reset with reads in flight
    for (int i = 0; i < 5; i++) push_op(0, 0, 'h500 + i, '0);
    repeat (4) run_cycle(1'b0);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    vq.delete(); aq.delete(); exp_side.delete();
    bus.Video_Req_I = 0; bus.Audio_Req_I = 0;
    m_own = -1; m_cnt = 0; m_ptr = 0; m_addr = '0; m_wdata = '0;
    obs_v.delete(); obs_a.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (10) run_cycle(1'b0);
    check("t5_no_valid", 64'(obs_v.size() + obs_a.size()), 64'd0);

    // Random traffic with busy stalls
    for (int c = 0; c < 1500; c++) begin
      if (vq.size() < 2 && $urandom_range(99) < 55)
        push_op(0, int'($urandom_range(99) < 35), int'($urandom_range(31)), $urandom);
      if (aq.size() < 2 && $urandom_range(99) < 55)
        push_op(1, int'($urandom_range(99) < 35), int'($urandom_range(31)), $urandom);
      run_cycle(1'($urandom_range(99) < 15));
    end
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
